// File: rtl/layer_pkg.sv
// Shared types and constants for the layer compositor and the sprite
// generators that must align with its pipeline latency.
package layer_pkg;

    localparam int LC_COLOR_W = 12;
    localparam int LC_COORD_W = 12;
    localparam int LC_LATENCY = 2;

    typedef logic [LC_COLOR_W-1:0] color_t;
    typedef logic [LC_COORD_W-1:0] coord_t;

    localparam color_t DEFAULT_BG_COLOR  = 12'hF00;
    localparam color_t DEFAULT_KEY_COLOR = 12'h000;

    // True when at least two bits of the vector are set.
    function automatic logic multi_hot(input logic [15:0] v);
        return (v & (v - 16'd1)) != 16'd0;
    endfunction

endpackage

// File: rtl/layer_priority_sel.sv
// Combinational priority select: the highest-index opaque layer wins.
module layer_priority_sel
    import layer_pkg::*;
#(
    parameter int N_LAYERS = 4,
    parameter int COLOR_W  = LC_COLOR_W
) (
    input  logic [N_LAYERS-1:0]         opaque,
    input  logic [N_LAYERS*COLOR_W-1:0] colors,
    output logic [COLOR_W-1:0]          color,
    output logic                        hit
);

    // Later (higher-index) layers overwrite earlier ones.
    always_comb begin
        color = '0;
        hit   = 1'b0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (opaque[i]) begin
                color = colors[i*COLOR_W +: COLOR_W];
                hit   = 1'b1;
            end else begin
                color = color;
                hit   = hit;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor with per-frame layer collision reporting.
// Collision logic is built only when LAYER_COMPOSITOR_COLLISION_EN is defined.
module layer_compositor
    import layer_pkg::*;
#(
    parameter int                  N_LAYERS  = 4,
    parameter int                  COLOR_W   = LC_COLOR_W,
    parameter int                  COORD_W   = LC_COORD_W,
    parameter int                  V_ACTIVE  = 1080,
    parameter logic [COLOR_W-1:0]  BG_COLOR  = DEFAULT_BG_COLOR,
    parameter logic [COLOR_W-1:0]  KEY_COLOR = DEFAULT_KEY_COLOR
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        video_on,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic [COORD_W-1:0]          h_count,
    input  logic [COORD_W-1:0]          v_count,
    input  logic [N_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [N_LAYERS-1:0]         layer_en,
    output logic [COLOR_W-1:0]          rgb,
    output logic                        hsync_out,
    output logic                        vsync_out,
    output logic                        video_on_out,
    output logic [N_LAYERS-1:0]         coll_mask,
    output logic                        frame_done
);

    logic [N_LAYERS-1:0]         opaque_s;
    logic                        boundary_s;
    logic [N_LAYERS*COLOR_W-1:0] s1_rgb_r;
    logic [N_LAYERS-1:0]         s1_opaque_r;
    logic                        s1_video_on_r, s1_hsync_r, s1_vsync_r, s1_boundary_r;
    logic [COLOR_W-1:0]          sel_color_s;
    logic                        sel_hit_s;
    logic [COLOR_W-1:0]          rgb_r;
    logic                        hsync_r, vsync_r, video_on_r;

    // A layer pixel is opaque when enabled and not equal to the key colour.
    always_comb begin
        opaque_s = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            opaque_s[i] = layer_en[i] && (layer_rgb[i*COLOR_W +: COLOR_W] != KEY_COLOR);
        end
    end

    assign boundary_s = (v_count == COORD_W'(V_ACTIVE)) && (h_count == '0);

    // Stage 1: capture colours, opacity, syncs and the frame-boundary flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_rgb_r      <= '0;
            s1_opaque_r   <= '0;
            s1_video_on_r <= 1'b0;
            s1_hsync_r    <= 1'b0;
            s1_vsync_r    <= 1'b0;
            s1_boundary_r <= 1'b0;
        end else begin
            s1_rgb_r      <= layer_rgb;
            s1_opaque_r   <= opaque_s;
            s1_video_on_r <= video_on;
            s1_hsync_r    <= hsync_in;
            s1_vsync_r    <= vsync_in;
            s1_boundary_r <= boundary_s;
        end
    end

    layer_priority_sel #(
        .N_LAYERS (N_LAYERS),
        .COLOR_W  (COLOR_W)
    ) u_sel (
        .opaque (s1_opaque_r),
        .colors (s1_rgb_r),
        .color  (sel_color_s),
        .hit    (sel_hit_s)
    );

    // Stage 2: blanking forces black; otherwise winner or background.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb_r      <= '0;
            hsync_r    <= 1'b0;
            vsync_r    <= 1'b0;
            video_on_r <= 1'b0;
        end else begin
            if (!s1_video_on_r) begin
                rgb_r <= '0;
            end else if (sel_hit_s) begin
                rgb_r <= sel_color_s;
            end else begin
                rgb_r <= BG_COLOR;
            end
            hsync_r    <= s1_hsync_r;
            vsync_r    <= s1_vsync_r;
            video_on_r <= s1_video_on_r;
        end
    end

    assign rgb          = rgb_r;
    assign hsync_out    = hsync_r;
    assign vsync_out    = vsync_r;
    assign video_on_out = video_on_r;

`ifdef LAYER_COMPOSITOR_COLLISION_EN
    logic [N_LAYERS-1:0] acc_r;
    logic [N_LAYERS-1:0] coll_mask_r;
    logic                frame_done_r;

    // Sticky collision accumulator; the frame boundary publishes and clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_r        <= '0;
            coll_mask_r  <= '0;
            frame_done_r <= 1'b0;
        end else if (s1_boundary_r) begin
            acc_r        <= '0;
            coll_mask_r  <= acc_r;
            frame_done_r <= 1'b1;
        end else begin
            if (s1_video_on_r && multi_hot(16'(s1_opaque_r))) begin
                acc_r <= acc_r | s1_opaque_r;
            end else begin
                acc_r <= acc_r;
            end
            coll_mask_r  <= coll_mask_r;
            frame_done_r <= 1'b0;
        end
    end

    assign coll_mask  = coll_mask_r;
    assign frame_done = frame_done_r;
`else
    logic unused_boundary_s;
    assign unused_boundary_s = s1_boundary_r;
    assign coll_mask  = '0;
    assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor (N_LAYERS = 4, default colours).
module tb_layer_compositor;

`ifdef LAYER_COMPOSITOR_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        vo;
        logic        hs;
        logic        vs;
        logic [11:0] h;
        logic [11:0] v;
        logic [3:0]  en;
        logic [47:0] rgbs;
    } pix_t;

    typedef struct packed {
        logic        vo;
        logic [3:0]  en;
        logic [47:0] rgbs;
        logic [11:0] exp_rgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, video_on, hsync_in, vsync_in;
    logic [11:0] h_count, v_count;
    logic [47:0] layer_rgb;
    logic [3:0]  layer_en;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, video_on_out, frame_done;
    logic [3:0]  coll_mask;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference-model state
    pix_t       prev_p;
    logic [3:0] m_acc, m_mask;
    logic       m_fd;

    always #5 clk = ~clk;

    layer_compositor #(.N_LAYERS(4)) dut (
        .clk(clk), .rst(rst), .video_on(video_on), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .h_count(h_count), .v_count(v_count),
        .layer_rgb(layer_rgb), .layer_en(layer_en), .rgb(rgb),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .video_on_out(video_on_out),
        .coll_mask(coll_mask), .frame_done(frame_done)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] opq(input pix_t p);
        logic [3:0] o;
        for (int i = 0; i < 4; i++) o[i] = p.en[i] && (p.rgbs[i*12 +: 12] != 12'h000);
        return o;
    endfunction

    // Highest-priority visible colour, searched from the top layer down.
    function automatic logic [11:0] comp(input pix_t p);
        if (!p.vo) return 12'h000;
        for (int i = 3; i >= 0; i--) begin
            if (p.en[i] && p.rgbs[i*12 +: 12] != 12'h000) return p.rgbs[i*12 +: 12];
        end
        return 12'hF00;
    endfunction

    function automatic pix_t mk(input logic vo, input logic [3:0] en, input logic [47:0] rgbs,
                                input logic [11:0] h, input logic [11:0] v);
        pix_t p;
        p = '0;
        p.rst = 1'b1; p.vo = vo; p.en = en; p.rgbs = rgbs; p.h = h; p.v = v;
        return p;
    endfunction

    // Drive one pixel, clock it, advance the model and compare every output.
    task automatic step(input pix_t p);
        logic [11:0] e_rgb;
        logic        e_hs, e_vs, e_vo;
        @(negedge clk);
        rst = p.rst; video_on = p.vo; hsync_in = p.hs; vsync_in = p.vs;
        h_count = p.h; v_count = p.v; layer_rgb = p.rgbs; layer_en = p.en;
        @(posedge clk);
        if (!p.rst || !prev_p.rst) begin
            e_rgb = 12'h000; e_hs = 1'b0; e_vs = 1'b0; e_vo = 1'b0; m_fd = 1'b0;
            if (!p.rst) begin m_acc = 4'h0; m_mask = 4'h0; end
        end else begin
            e_rgb = comp(prev_p); e_hs = prev_p.hs; e_vs = prev_p.vs; e_vo = prev_p.vo;
            if (prev_p.v == 12'd1080 && prev_p.h == 12'd0) begin
                m_mask = m_acc; m_acc = 4'h0; m_fd = 1'b1;
            end else begin
                m_fd = 1'b0;
                if (prev_p.vo && $countones(opq(prev_p)) >= 2) m_acc = m_acc | opq(prev_p);
            end
        end
        #1;
        chk("outputs", {12'h0, rgb, hsync_out, vsync_out, video_on_out, coll_mask, frame_done},
            {12'h0, e_rgb, e_hs, e_vs, e_vo, COLL_EN ? m_mask : 4'h0, COLL_EN ? m_fd : 1'b0});
        prev_p = p;
    endtask

    vec_t tv[8];
    pix_t idle, bnd, p;

    initial begin
        prev_p = '0; m_acc = 4'h0; m_mask = 4'h0; m_fd = 1'b0;
        idle = mk(1'b0, 4'h0, 48'h0, 12'd5, 12'd5);
        bnd  = mk(1'b0, 4'h0, 48'h0, 12'd0, 12'd1080);

        tv[0] = '{1'b1, 4'hF, 48'h0, 12'hF00};
        tv[1] = '{1'b1, 4'hF, {12'h000, 12'h0F0, 12'h000, 12'hFFF}, 12'h0F0};
        tv[2] = '{1'b1, 4'b1011, {12'h000, 12'h0F0, 12'h000, 12'hFFF}, 12'hFFF};
        tv[3] = '{1'b0, 4'hF, {12'hFFF, 12'h000, 12'h000, 12'h000}, 12'h000};
        tv[4] = '{1'b1, 4'b0111, {12'hFFF, 12'h000, 12'h000, 12'h000}, 12'hF00};
        tv[5] = '{1'b1, 4'hF, {12'h000, 12'h000, 12'h123, 12'h000}, 12'h123};
        tv[6] = '{1'b1, 4'hF, {12'h444, 12'h333, 12'h222, 12'h111}, 12'h444};
        tv[7] = '{1'b1, 4'h0, {12'h444, 12'h333, 12'h222, 12'h111}, 12'hF00};

        // Reset state
        p = idle; p.rst = 1'b0;
        step(p); step(p);
        chk("reset_rgb", {20'h0, rgb}, 32'h0);
        chk("reset_coll", {27'h0, coll_mask, frame_done}, 32'h0);

        // Table: hold each vector two clocks, then check the composited colour
        for (int k = 0; k < 8; k++) begin
            p = mk(tv[k].vo, tv[k].en, tv[k].rgbs, 12'd20, 12'd20);
            step(p); step(p);
            chk($sformatf("table_rgb[%0d]", k), {20'h0, rgb}, {20'h0, tv[k].exp_rgb});
        end

        // hsync pulse appears exactly two clocks later
        p = idle; p.hs = 1'b1;
        step(p);
        chk("hsync_lat1", {31'h0, hsync_out}, 32'h0);
        step(idle);
        chk("hsync_lat2", {31'h0, hsync_out}, 32'h1);
        step(idle);
        chk("hsync_lat3", {31'h0, hsync_out}, 32'h0);

        // Flush the accumulator, then layers 1 and 3 overlap at (10,10)
        step(bnd); step(idle); step(idle);
        step(mk(1'b1, 4'hF, {12'h00B, 12'h000, 12'h0A0, 12'h000}, 12'd10, 12'd10));
        step(mk(1'b1, 4'hF, {12'h000, 12'h000, 12'h0A0, 12'h000}, 12'd11, 12'd10));
        step(bnd); step(idle);
        chk("s4_frame_done", {31'h0, frame_done}, {31'h0, COLL_EN});
        chk("s4_mask", {28'h0, coll_mask}, COLL_EN ? 32'hA : 32'h0);
        step(idle);
        chk("s4_pulse_width", {31'h0, frame_done}, 32'h0);
        chk("s4_mask_held", {28'h0, coll_mask}, COLL_EN ? 32'hA : 32'h0);
        step(mk(1'b1, 4'hF, {12'h00B, 12'h000, 12'h000, 12'h000}, 12'd10, 12'd10));
        step(bnd); step(idle);
        chk("s4_clean_mask", {27'h0, coll_mask, frame_done}, {27'h0, 4'h0, COLL_EN});

        // Disabled layer and blanked overlap never count
        step(mk(1'b1, 4'b0001, {12'h000, 12'h000, 12'h0A0, 12'h0C0}, 12'd3, 12'd3));
        step(mk(1'b0, 4'hF, {12'h000, 12'h000, 12'h0A0, 12'h0C0}, 12'd4, 12'd3));
        step(bnd); step(idle);
        chk("s5_mask", {27'h0, coll_mask, frame_done}, {27'h0, 4'h0, COLL_EN});

        // Reset mid-frame after an overlap
        step(mk(1'b1, 4'hF, {12'h000, 12'h000, 12'h0A0, 12'h0C0}, 12'd6, 12'd6));
        step(mk(1'b1, 4'hF, {12'h000, 12'h000, 12'h0A0, 12'h0C0}, 12'd7, 12'd6));
        p = idle; p.rst = 1'b0; p.hs = 1'b1;
        step(p);
        chk("s6_reset_out", {12'h0, rgb, hsync_out, vsync_out, video_on_out, coll_mask, frame_done}, 32'h0);
        step(mk(1'b1, 4'hF, {12'h000, 12'h000, 12'h000, 12'h0C0}, 12'd8, 12'd6));
        step(bnd); step(idle);
        chk("s6_after_reset", {27'h0, coll_mask, frame_done}, {27'h0, 4'h0, COLL_EN});

        // Randomised traffic checked cycle by cycle against the model
        for (int n = 0; n < 3000; n++) begin
            p = '0;
            p.rst = ($urandom_range(0, 199) != 0);
            p.vo  = ($urandom_range(0, 3) != 0);
            p.hs  = $urandom_range(0, 1);
            p.vs  = $urandom_range(0, 1);
            p.en  = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                p.rgbs[i*12 +: 12] = ($urandom_range(0, 2) == 0) ? 12'h000 : 12'($urandom);
            end
            if ($urandom_range(0, 49) == 0) begin
                p.h = 12'd0; p.v = 12'd1080;
            end else begin
                p.h = 12'($urandom_range(0, 3)); p.v = 12'($urandom_range(1078, 1081));
            end
            step(p);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised, pipelined pixel compositor that merges `N_LAYERS` sprite colour streams (paddles, ball, overlays) into one VGA colour, replacing the fixed priority chain in the game top level. It sits between the sprite generators and the VGA pins. It keeps sync and `video_on` aligned with the pixel pipeline. It also reports, once per frame, which layers overlapped another opaque layer, for ball/paddle collision logic.

## Interface
Parameters:
- `N_LAYERS`, 4, number of input layers (2..16); higher index = higher priority
- `COLOR_W`, 12, colour width (4:4:4 RGB)
- `COORD_W`, 12, width of `h_count` / `v_count`
- `V_ACTIVE`, 1080, first non-visible line; frame boundary line
- `BG_COLOR`, 12'hF00, colour when no layer is opaque
- `KEY_COLOR`, 12'h000, transparent key; a layer pixel equal to it is transparent

Ports:
- `clk`  in  1  pixel clock (148.5 MHz domain)
- `rst`  in  1  reset, synchronous, active-low
- `video_on`  in  1  active-video flag from the VGA controller
- `hsync_in` / `vsync_in`  in  1  raw syncs from the VGA controller
- `h_count` / `v_count`  in  `COORD_W`  current pixel coordinates
- `layer_rgb`  in  `N_LAYERS*COLOR_W`  layer i at bits `[i*COLOR_W +: COLOR_W]`
- `layer_en`  in  `N_LAYERS`  per-layer enable; 0 = forced transparent
- `rgb`  out  `COLOR_W`  composited colour
- `hsync_out` / `vsync_out` / `video_on_out`  out  1  syncs and flag delayed to match `rgb`
- `coll_mask`  out  `N_LAYERS`  bit i = layer i overlapped another opaque layer in the last completed frame
- `frame_done`  out  1  one-cycle pulse when `coll_mask` updates

## Operation
- Opaque(i) = `layer_en[i]` && `layer_rgb[i]` != `KEY_COLOR`.
- **Stage 1** registers the following:
  - all layer colours
  - the opaque vector
  - `video_on`, the syncs
  - a frame-boundary flag: (`v_count` == `V_ACTIVE` && `h_count` == 0).
- **Stage 2** computes the following:
  - `rgb` = colour of the highest-index opaque layer.
  - If no layer is opaque, `rgb` = `BG_COLOR`.
  - If stage-1 `video_on` = 0, `rgb` = 0 regardless of layers.
- **Collision accumulator:**
  - It is an `N_LAYERS`-bit sticky register.
  - During stage-1 `video_on` = 1 with two or more opaque layers, every opaque bit is OR-ed in.
  - Pixels with `video_on` = 0 never contribute.
- **Frame boundary** (stage-1 flag = 1):
  - `coll_mask` <= accumulator.
  - Accumulator <= 0.
  - `frame_done` = 1 for exactly that cycle.
  - If the boundary cycle and a collision cycle coincide, the boundary wins. This cannot occur because the boundary line is outside active video.
- `layer_en` changes take effect on the next pixel; there is no per-frame latching.
- No state machine beyond the pipeline and the accumulator/boundary logic.

## Timing
- Latency: 2 clocks, for every input to `rgb`, `hsync_out`, `vsync_out`, `video_on_out`. Throughput is 1 pixel per clock with no stalls.
- `coll_mask` and `frame_done` are valid 2 clocks after the input cycle carrying `v_count` == `V_ACTIVE`, `h_count` == 0.
- Reset (`rst` = 0 at a rising edge) clears the following to 0 on that edge:
  - `rgb`, `hsync_out`, `vsync_out`, `video_on_out`
  - `coll_mask`, `frame_done`
  - the accumulator and all pipeline registers.
- Reset mid-frame:
  - The pipeline is flushed.
  - The first `frame_done` after release reports only pixels seen since release.
  - Valid output resumes 2 clocks after release.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `LAYER_COMPOSITOR_COLLISION_EN` defined:
  - Accumulator, `coll_mask` and `frame_done` behave as above.
- Not defined:
  - Accumulator and boundary logic are not built.
  - `coll_mask` is tied to 0 and `frame_done` is tied to 0.
  - Pixel path and latency are unchanged.

## Structure
- Package `layer_pkg` holds:
  - `color_t` (logic [COLOR_W-1:0]) and `coord_t`
  - default `BG_COLOR` / `KEY_COLOR` localparams
  - the pipeline latency constant `LC_LATENCY` = 2, so that sprite generators can align.
- One sub-module, `layer_priority_sel`. It is combinational, parametrised by `N_LAYERS`. It takes the opaque vector and colours, and returns the winning colour plus a `hit` flag. The top instance registers its output in stage 2.

## Test plan
With `N_LAYERS` = 4 and defaults:
1. All `layer_rgb` = 0, `video_on` = 1 -> `rgb` = 12'hF00 two clocks later.
2. Layer0 = 12'hFFF and layer2 = 12'h0F0, both enabled -> `rgb` = 12'h0F0. Then drop `layer_en[2]` -> `rgb` = 12'hFFF after 2 clocks.
3. `video_on` = 0 with layer3 = 12'hFFF -> `rgb` = 12'h000. Toggle `hsync_in` -> `hsync_out` follows exactly 2 clocks later.
4. Layers 1 and 3 opaque together at pixel (10,10) in one frame -> at the boundary, `frame_done` pulses for 1 cycle and `coll_mask` = 4'b1010. Next frame with no overlap -> `coll_mask` = 4'b0000.
5. Layers 0 and 1 overlap with `layer_en[1]` = 0 -> `coll_mask` = 4'b0000. Overlap only during `video_on` = 0 -> `coll_mask` = 4'b0000.
6. `rst` = 0 mid-frame after an overlap -> all outputs 0 on the next edge. After release, a frame without overlap -> `coll_mask` = 4'b0000. With the macro undefined, scenario 4 gives `coll_mask` = 0 and no `frame_done`.
